tester_db_reg_bank: RTL and testbench

Parametrised bank of NUM_CH double-buffered tester registers, WIDTH bits each, for pin-drive and tristate-enable words.
Shadow words load by addressed parallel write or a serial scan chain.
A single TRANSFER commits every shadow word to the active outputs at once; if the shadow is busy, the transfer is queued, not dropped.
The bank sits between the host command decoder and the DUT pin drivers.

---
 rtl/tester_db_pkg.sv | 23 ++
 rtl/tester_db_word.sv | 52 +++++
 rtl/tester_db_reg_bank.sv | 148 ++++++++++++++
 tb/tb_tester_db_reg_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tester_db_pkg.sv
// Shared types and helpers for the double-buffered tester register bank.
package tester_db_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StPending
    } xfer_state_e;

    // Active words default to all ones so pin tristates come up disabled.
    localparam logic DefaultRstBit = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tester_db_word.sv
// One channel: shadow word (parallel load / serial shift) and active word (commit / force).
// The shadow output exists only when DB_REG_READBACK_EN is defined.
module tester_db_word
    import tester_db_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] RST_Q = {WIDTH{DefaultRstBit}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift,
    input  logic             sdi,
    input  logic             commit,
    input  logic             force_dflt,
    output logic             sdo,
    output logic [WIDTH-1:0] active
`ifdef DB_REG_READBACK_EN
    ,
    output logic [WIDTH-1:0] shadow
`endif
);

    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] active_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            shadow_q <= '0;
            active_q <= RST_Q;
        end else begin
            if (load) begin
                shadow_q <= d;
            end else if (shift) begin
                shadow_q <= {shadow_q[WIDTH-2:0], sdi};
            end
            if (force_dflt) begin
                active_q <= RST_Q;
            end else if (commit) begin
                active_q <= shadow_q;
            end
        end
    end

    assign sdo    = shadow_q[WIDTH-1];
    assign active = active_q;
`ifdef DB_REG_READBACK_EN
    assign shadow = shadow_q;
`endif

endmodule

// File: rtl/tester_db_reg_bank.sv
// Bank of NUM_CH double-buffered tester words with a queued TRANSFER commit.
// Optional registered readback (RD_SEL/RDATA) when DB_REG_READBACK_EN is defined.
module tester_db_reg_bank
    import tester_db_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter int unsigned      NUM_CH = 4,
    parameter int unsigned      AW     = 2,
    parameter logic [WIDTH-1:0] RST_Q  = {WIDTH{DefaultRstBit}}
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    DISABLE_ALL_TRISTATES,
    input  logic                    LOAD,
    input  logic [AW-1:0]           ADDR,
    input  logic [WIDTH-1:0]        D,
    input  logic                    SHIFT,
    input  logic                    SDI,
    output logic                    SDO,
    input  logic                    TRANSFER,
    output logic [NUM_CH*WIDTH-1:0] Q,
    output logic                    XFER_PENDING,
    output logic                    XFER_DONE,
    output logic                    SCAN_FULL
`ifdef DB_REG_READBACK_EN
    ,
    input  logic                    RD_SEL,
    output logic [WIDTH-1:0]        RDATA
`endif
);

    localparam int unsigned N    = NUM_CH * WIDTH;
    localparam int unsigned CntW = clog2(N + 1);

    xfer_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            done_q;
    logic            busy;
    logic            commit;
    logic            shift_en;
    logic [NUM_CH:0] chain;

    assign busy     = LOAD | SHIFT;
    assign shift_en = SHIFT & ~LOAD;

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        if (DISABLE_ALL_TRISTATES) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (TRANSFER) begin
                        if (busy) begin
                            state_d = StPending;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                end
                StPending: begin
                    if (!busy) begin
                        commit  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= commit;
            if (commit) begin
                cnt_q <= '0;
            end else if (shift_en && cnt_q != CntW'(N)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign XFER_PENDING = (state_q == StPending);
    assign XFER_DONE    = done_q;
    assign SCAN_FULL    = (cnt_q == CntW'(N));

    // Chain runs from SDI into channel 0 bit 0 up to channel NUM_CH-1 MSB.
    assign chain[0] = SDI;
    assign SDO      = chain[NUM_CH];

`ifdef DB_REG_READBACK_EN
    logic [WIDTH-1:0] shadow [NUM_CH];
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tester_db_word #(
            .WIDTH(WIDTH),
            .RST_Q(RST_Q)
        ) u_word (
            .CLK       (CLK),
            .RST       (RST),
            .load      (LOAD && (ADDR == AW'(c))),
            .d         (D),
            .shift     (shift_en),
            .sdi       (chain[c]),
            .commit    (commit),
            .force_dflt(DISABLE_ALL_TRISTATES),
            .sdo       (chain[c+1]),
            .active    (Q[c*WIDTH +: WIDTH])
`ifdef DB_REG_READBACK_EN
            ,
            .shadow    (shadow[c])
`endif
        );
    end

`ifdef DB_REG_READBACK_EN
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] rdata_q;

    // Out-of-range addresses match no channel and read as zero.
    always_comb begin
        rd_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ADDR == AW'(c)) begin
                rd_word = RD_SEL ? Q[c*WIDTH +: WIDTH] : shadow[c];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rd_word;
        end
    end

    assign RDATA = rdata_q;
`endif

endmodule

// File: tb/tb_tester_db_reg_bank.sv
// Randomized and directed bench for tester_db_reg_bank against a flat-vector reference model.
module tb_tester_db_reg_bank;

    logic        CLK = 1'b0;
    logic        RST, DISABLE_ALL_TRISTATES, LOAD, SHIFT, SDI, TRANSFER;
    logic [1:0]  ADDR;
    logic [7:0]  D;
    logic        SDO, XFER_PENDING, XFER_DONE, SCAN_FULL;
    logic [31:0] Q;
    logic        RD_SEL;
    logic [7:0]  RDATA;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: whole shadow as one vector, pending as a flag.
    logic [31:0] m_q, m_sh;
    logic        m_pend, m_done;
    int          m_cnt;
    logic [7:0]  m_rdata;

    always #5 CLK = ~CLK;

    tester_db_reg_bank #(
        .WIDTH (8),
        .NUM_CH(4),
        .AW    (2)
    ) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .DISABLE_ALL_TRISTATES(DISABLE_ALL_TRISTATES),
        .LOAD                 (LOAD),
        .ADDR                 (ADDR),
        .D                    (D),
        .SHIFT                (SHIFT),
        .SDI                  (SDI),
        .SDO                  (SDO),
        .TRANSFER             (TRANSFER),
        .Q                    (Q),
        .XFER_PENDING         (XFER_PENDING),
        .XFER_DONE            (XFER_DONE),
        .SCAN_FULL            (SCAN_FULL)
`ifdef DB_REG_READBACK_EN
        ,
        .RD_SEL               (RD_SEL),
        .RDATA                (RDATA)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic dis, input logic ld, input logic [1:0] ad,
                        input logic [7:0] dd, input logic sh, input logic si, input logic xf,
                        input logic rs);
        logic busy, commit;
        RST = rst; DISABLE_ALL_TRISTATES = dis; LOAD = ld; ADDR = ad; D = dd;
        SHIFT = sh; SDI = si; TRANSFER = xf; RD_SEL = rs;
        @(posedge CLK);
        busy = ld | sh;
        if (rst) begin
            m_q = '1; m_sh = '0; m_pend = 0; m_done = 0; m_cnt = 0; m_rdata = '0;
        end else begin
            commit  = !dis && !busy && (m_pend || xf);
            m_rdata = rs ? m_q[ad*8 +: 8] : m_sh[ad*8 +: 8];
            if (commit) begin
                m_q   = m_sh;
                m_cnt = 0;
            end
            if (dis) m_q = '1;
            m_pend = !dis && busy && (m_pend || xf);
            m_done = commit;
            if (ld) begin
                m_sh[ad*8 +: 8] = dd;
            end else if (sh) begin
                m_sh = {m_sh[30:0], si};
                if (m_cnt < 32) m_cnt++;
            end
        end
        #1;
        check_eq("q", Q, m_q);
        check_eq("sdo", 32'(SDO), 32'(m_sh[31]));
        check_eq("pending", 32'(XFER_PENDING), 32'(m_pend));
        check_eq("done", 32'(XFER_DONE), 32'(m_done));
        check_eq("scan_full", 32'(SCAN_FULL), 32'(m_cnt == 32));
`ifdef DB_REG_READBACK_EN
        check_eq("rdata", 32'(RDATA), 32'(m_rdata));
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, 2'd0, 8'h00, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] keep;
        int          pend_cnt, done_cnt;
        logic        ld, sh, dis;

        // 1: reset, addressed load, commit
        step(1, 0, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        step(1, 0, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        check_eq("rst_q", Q, 32'hFFFF_FFFF);
        check_eq("rst_sdo", 32'(SDO), 32'd0);
        check_eq("rst_flags", {29'd0, XFER_PENDING, XFER_DONE, SCAN_FULL}, 32'd0);
        step(0, 0, 1, 2'd2, 8'hA5, 0, 0, 0, 0);
        check_eq("load_no_commit", Q, 32'hFFFF_FFFF);
        step(0, 0, 0, 2'd0, 8'h00, 0, 0, 1, 0);
        check_eq("load_commit_q", Q, 32'h00A5_0000);
        check_eq("load_commit_done", 32'(XFER_DONE), 32'd1);
        idle();
        check_eq("done_one_cycle", 32'(XFER_DONE), 32'd0);

        // 2: full scan then commit
        pat = 32'h1234_5678;
        for (int i = 31; i >= 0; i--) step(0, 0, 0, 2'd0, 8'h00, 1, pat[i], 0, 0);
        check_eq("scan_full_set", 32'(SCAN_FULL), 32'd1);
        step(0, 0, 0, 2'd0, 8'h00, 0, 0, 1, 0);
        check_eq("scan_commit_q", Q, 32'h1234_5678);
        check_eq("scan_full_clr", 32'(SCAN_FULL), 32'd0);

        // 3: transfer queued behind three shifts
        pend_cnt = 0;
        done_cnt = 0;
        keep = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            logic b;
            b = 1'($urandom);
            keep = {keep[30:0], b};
            step(0, 0, 0, 2'd0, 8'h00, 1, b, (i == 0), 0);
            if (XFER_PENDING) pend_cnt++;
            if (XFER_DONE) done_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            if (XFER_PENDING) pend_cnt++;
            if (XFER_DONE) done_cnt++;
        end
        check_eq("pending_cycles", 32'(pend_cnt), 32'd3);
        check_eq("single_done", 32'(done_cnt), 32'd1);
        check_eq("queued_commit_q", Q, keep);

        // 4: disable swallows same-cycle transfer, shadow survives
        step(0, 0, 1, 2'd0, 8'h77, 0, 0, 0, 0);
        keep[7:0] = 8'h77;
        step(0, 1, 0, 2'd0, 8'h00, 0, 0, 1, 0);
        check_eq("disable_q", Q, 32'hFFFF_FFFF);
        idle();
        check_eq("disable_no_done", 32'(XFER_DONE), 32'd0);
        step(0, 0, 0, 2'd0, 8'h00, 0, 0, 1, 0);
        check_eq("restore_q", Q, keep);

        // 5: load beats shift without counting; reset while pending
        for (int i = 0; i < 31; i++) step(0, 0, 0, 2'd0, 8'h00, 1, 1'($urandom), 0, 0);
        step(0, 0, 1, 2'd3, 8'h5A, 1, 1, 0, 0);
        check_eq("ld_sh_count_hold", 32'(SCAN_FULL), 32'd0);
        step(0, 0, 0, 2'd0, 8'h00, 0, 0, 1, 0);
        check_eq("addr3_load", 32'(Q[31:24]), 32'h5A);
        step(0, 0, 0, 2'd0, 8'h00, 1, 1, 1, 0);
        check_eq("pending_set", 32'(XFER_PENDING), 32'd1);
        step(1, 0, 0, 2'd0, 8'h00, 0, 0, 0, 0);
        check_eq("rst_pending_q", Q, 32'hFFFF_FFFF);
        check_eq("rst_pending_flags", {30'd0, XFER_PENDING, XFER_DONE}, 32'd0);

`ifdef DB_REG_READBACK_EN
        // 6: readback shadow vs active
        step(0, 0, 1, 2'd1, 8'h3C, 0, 0, 0, 0);
        step(0, 0, 0, 2'd1, 8'h00, 0, 0, 0, 0);
        check_eq("rd_shadow", 32'(RDATA), 32'h3C);
        step(0, 0, 0, 2'd1, 8'h00, 0, 0, 0, 1);
        check_eq("rd_active", 32'(RDATA), 32'hFF);
`endif

        // Random traffic; disable only on non-busy cycles.
        for (int i = 0; i < 1500; i++) begin
            ld  = ($urandom_range(0, 7) == 0);
            sh  = ($urandom_range(0, 1) == 0);
            dis = !ld && !sh && ($urandom_range(0, 15) == 0);
            step(($urandom_range(0, 199) == 0), dis, ld, 2'($urandom), 8'($urandom), sh,
                 1'($urandom), ($urandom_range(0, 39) == 0), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
